// File: rtl/axi_ar_id_arbiter.sv
// Round-robin AXI read-channel arbiter: merges NoSlvPorts AR streams onto one
// master port, tagging IDs with the port index, and routes R beats back by that tag.

module axi_ar_id_arbiter_cnt #(
  parameter int unsigned MaxTxns  = 8,
  parameter int unsigned CntWidth = $clog2(MaxTxns + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);
  logic [CntWidth-1:0] cnt;

  // Simultaneous issue and completion cancel; decrement saturates at zero.
  always_ff @(posedge clk_i) begin
    if (rst_i)                             cnt <= '0;
    else if (inc && !dec)                  cnt <= cnt + 1'b1;
    else if (dec && !inc && cnt != '0)     cnt <= cnt - 1'b1;
  end

  assign full  = (cnt == CntWidth'(MaxTxns));
  assign empty = (cnt == '0);
endmodule

module axi_ar_id_arbiter #(
  parameter  int unsigned NoSlvPorts     = 4,
  parameter  int unsigned IdWidthSlv     = 4,
  parameter  int unsigned ArPayloadWidth = 64,
  parameter  int unsigned DataWidth      = 64,
  parameter  int unsigned MaxTxns        = 8,
  localparam int unsigned SelWidth       = $clog2(NoSlvPorts),
  localparam int unsigned IdWidthMst     = IdWidthSlv + SelWidth,
  localparam int unsigned CntWidth       = $clog2(MaxTxns + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NoSlvPorts*IdWidthSlv-1:0]     slv_ar_id_i,
  input  logic [NoSlvPorts*ArPayloadWidth-1:0] slv_ar_payload_i,
  input  logic [NoSlvPorts-1:0]                slv_ar_valid_i,
  output logic [NoSlvPorts-1:0]                slv_ar_ready_o,
  output logic [NoSlvPorts*IdWidthSlv-1:0]     slv_r_id_o,
  output logic [NoSlvPorts*DataWidth-1:0]      slv_r_data_o,
  output logic [NoSlvPorts*2-1:0]              slv_r_resp_o,
  output logic [NoSlvPorts-1:0]                slv_r_last_o,
  output logic [NoSlvPorts-1:0]                slv_r_valid_o,
  input  logic [NoSlvPorts-1:0]                slv_r_ready_i,
  output logic [IdWidthMst-1:0]                mst_ar_id_o,
  output logic [ArPayloadWidth-1:0]            mst_ar_payload_o,
  output logic                                 mst_ar_valid_o,
  input  logic                                 mst_ar_ready_i,
  input  logic [IdWidthMst-1:0]                mst_r_id_i,
  input  logic [DataWidth-1:0]                 mst_r_data_i,
  input  logic [1:0]                           mst_r_resp_i,
  input  logic                                 mst_r_last_i,
  input  logic                                 mst_r_valid_i,
  output logic                                 mst_r_ready_o,
  output logic                                 busy_o,
  output logic                                 err_o
);
  logic [NoSlvPorts-1:0][IdWidthSlv-1:0]     ar_id;
  logic [NoSlvPorts-1:0][ArPayloadWidth-1:0] ar_pl;
  logic [SelWidth-1:0] ptr, lock_idx, win_idx, grant, sel;
  logic lock, win_found, ar_hs, r_hs, sel_ok, err_d, err_q, busy_q;
  logic [NoSlvPorts-1:0] elig, full, empty, inc, dec, sel_oh;

  assign ar_id = slv_ar_id_i;
  assign ar_pl = slv_ar_payload_i;
  assign elig  = slv_ar_valid_i & ~full;

  // First eligible port at or after the pointer, wrapping.
  always_comb begin
    logic [SelWidth-1:0] j;
    win_found = 1'b0;
    win_idx   = '0;
    j         = '0;
    for (int i = 0; i < int'(NoSlvPorts); i++) begin
      j = SelWidth'((int'(ptr) + i) % int'(NoSlvPorts));
      if (!win_found && elig[j]) begin
        win_found = 1'b1;
        win_idx   = j;
      end
    end
  end

  // A pending request keeps its grant so id/payload stay stable until accepted.
  assign grant            = lock ? lock_idx : win_idx;
  assign mst_ar_valid_o   = !rst_i && (win_found || lock);
  assign ar_hs            = mst_ar_valid_o && mst_ar_ready_i;
  assign mst_ar_id_o      = {grant, ar_id[grant]};
  assign mst_ar_payload_o = ar_pl[grant];

  always_comb begin
    for (int k = 0; k < int'(NoSlvPorts); k++) begin
      inc[k]    = ar_hs && (grant == SelWidth'(k));
      sel_oh[k] = (sel == SelWidth'(k));
    end
  end
  assign slv_ar_ready_o = inc;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr      <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
    end else if (ar_hs) begin
      lock <= 1'b0;
      ptr  <= (grant == SelWidth'(NoSlvPorts - 1)) ? '0 : grant + 1'b1;
    end else if (mst_ar_valid_o) begin
      lock     <= 1'b1;
      lock_idx <= grant;
    end
  end

  // Out-of-range tags are swallowed so a bad beat can never wedge the R channel.
  assign sel           = mst_r_id_i[IdWidthMst-1 -: SelWidth];
  assign sel_ok        = |sel_oh;
  assign mst_r_ready_o = !rst_i && (sel_ok ? |(slv_r_ready_i & sel_oh) : 1'b1);
  assign slv_r_valid_o = (!rst_i && mst_r_valid_i) ? sel_oh : '0;
  assign r_hs          = mst_r_valid_i && mst_r_ready_o;
  assign dec           = (r_hs && mst_r_last_i) ? sel_oh : '0;
  assign err_d         = r_hs && (!sel_ok || (mst_r_last_i && |(sel_oh & empty)));

  assign slv_r_id_o   = {NoSlvPorts{mst_r_id_i[IdWidthSlv-1:0]}};
  assign slv_r_data_o = {NoSlvPorts{mst_r_data_i}};
  assign slv_r_resp_o = {NoSlvPorts{mst_r_resp_i}};
  assign slv_r_last_o = {NoSlvPorts{mst_r_last_i}};

  axi_ar_id_arbiter_cnt #(.MaxTxns(MaxTxns), .CntWidth(CntWidth)) u_cnt [NoSlvPorts-1:0] (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (inc),
    .dec   (dec),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      err_q  <= err_d;
      busy_q <= |(~empty);
    end
  end

  assign err_o  = err_q && !rst_i;
  assign busy_o = busy_q && !rst_i;
endmodule

// File: doc/axi_ar_id_arbiter.md
Name: axi_ar_id_arbiter

Overview:
- Shares one AXI read master port between NoSlvPorts requesters.
- Arbitrates AR requests round-robin and prepends the winning port index as the ID MSBs.
- Routes R beats back to the requester by stripping those MSBs.
- Tracks outstanding reads per port and throttles a port that reaches MaxTxns; sits between the read masters and the crossbar/memory.

Parameters:
- NoSlvPorts, 4, number of requesting read ports (>=2).
- IdWidthSlv, 4, AR/R ID width on the slave ports.
- SelWidth, $clog2(NoSlvPorts), DEPENDENT: prepended index width.
- IdWidthMst, IdWidthSlv+SelWidth, DEPENDENT: master port ID width.
- ArPayloadWidth, 64, width of the remaining packed AR fields (addr, len, size, burst, cache, prot, qos, ...), passed through untouched.
- DataWidth, 64, R data width.
- MaxTxns, 8, maximum outstanding read bursts per port (>=1).
- CntWidth, $clog2(MaxTxns+1), DEPENDENT.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- slv_ar_id_i  in  NoSlvPorts*IdWidthSlv  per-port AR ID
- slv_ar_payload_i  in  NoSlvPorts*ArPayloadWidth  per-port AR payload
- slv_ar_valid_i  in  NoSlvPorts  AR valid
- slv_ar_ready_o  out  NoSlvPorts  AR ready
- slv_r_id_o  out  NoSlvPorts*IdWidthSlv  R ID (stripped)
- slv_r_data_o  out  NoSlvPorts*DataWidth  R data (broadcast)
- slv_r_resp_o  out  NoSlvPorts*2  R resp
- slv_r_last_o  out  NoSlvPorts  R last
- slv_r_valid_o  out  NoSlvPorts  R valid
- slv_r_ready_i  in  NoSlvPorts  R ready
- mst_ar_id_o  out  IdWidthMst  {index, slave ID}
- mst_ar_payload_o  out  ArPayloadWidth  AR payload of granted port
- mst_ar_valid_o  out  1  AR valid
- mst_ar_ready_i  in  1  AR ready
- mst_r_id_i  in  IdWidthMst  R ID
- mst_r_data_i  in  DataWidth  R data
- mst_r_resp_i  in  2  R resp
- mst_r_last_i  in  1  R last
- mst_r_valid_i  in  1  R valid
- mst_r_ready_o  out  1  R ready
- busy_o  out  1  any per-port counter non-zero
- err_o  out  1  one-cycle pulse on illegal R routing

Behaviour:
- Reset (rst_i high at a clk_i edge, synchronous): RR pointer=0, lock=0, all counters=0, err_o=0.
  - While in reset: all *_valid_o, *_ready_o and busy_o are 0.
  - Reset mid-burst drops all outstanding tracking; no recovery of in-flight beats.
- Eligibility: port k is eligible iff slv_ar_valid_i[k] and cnt[k] < MaxTxns.
- Arbitration: combinational round-robin, zero-latency AR path.
  - The winner is the first eligible port at or after the pointer, wrapping NoSlvPorts-1 -> 0.
  - mst_ar_valid_o = a winner exists or lock is set.
- Lock: if mst_ar_valid_o is high and mst_ar_ready_i is low, the grant index is registered and held until handshake.
  - A higher-priority arrival must not change mst_ar_id_o or mst_ar_payload_o while valid is pending (AXI stability).
- AR handshake on port k:
  - slv_ar_ready_o[k] = mst_ar_ready_i; all other slv_ar_ready_o are 0.
  - mst_ar_id_o = {k[SelWidth-1:0], slv_ar_id_i[k]}.
  - Pointer <= (k+1) mod NoSlvPorts; lock cleared; cnt[k] increments.
- R routing: sel = mst_r_id_i[IdWidthMst-1 -: IdWidthSlv... MSB SelWidth bits].
  - slv_r_valid_o[sel] = mst_r_valid_i; mst_r_ready_o = slv_r_ready_i[sel].
  - Data, resp and last are broadcast; slv_r_id_o = lower IdWidthSlv bits of mst_r_id_i.
- R completion: a handshake with mst_r_last_i=1 decrements cnt[sel].
- Same-cycle AR handshake and R-last handshake on the same port: cnt unchanged.
- Illegal R beat: sel >= NoSlvPorts (non-power-of-2 NoSlvPorts), or an R-last handshake when cnt[sel]==0.
  - Out-of-range sel: mst_r_ready_o=1, beat dropped, no slave valid raised, err_o pulses the next cycle.
  - R-last with cnt[sel]==0: beat is forwarded, counter saturates at 0, err_o pulses the next cycle.
- Full: when cnt[k]==MaxTxns, port k is skipped in arbitration and slv_ar_ready_o[k]=0 even if mst_ar_ready_i is high.
- busy_o is registered: high the cycle after any counter becomes non-zero; low the cycle after all counters reach 0.

Test Plan:
- Reset held 3 cycles with all ports valid -> mst_ar_valid_o=0, all slv_ar_ready_o=0, busy_o=0; after release port 0 is granted first.
- Ports 0..3 valid, IDs 0xA/0xB/0xC/0xD, mst_ar_ready_i=1 constantly -> mst_ar_id_o sequence 0x0A, 0x1B, 0x2C, 0x3D, 0x0A, then repeating.
- Port 2 valid, mst_ar_ready_i=0 for 5 cycles, port 0 raises valid at cycle 2 -> mst_ar_id_o stays {2,id2} and payload is stable until handshake; port 0 is granted next.
- Port 1 issues MaxTxns=8 ARs with no R -> 9th AR stalls (slv_ar_ready_o[1]=0) while port 3 is still granted.
  - One R-last with ID 0x1_5 -> slv_r_valid_o[1]=1, slv_r_id_o[1]=0x5, port 1 AR accepted again the next cycle.
- Same-cycle AR handshake and R-last on port 0 with cnt=3 -> cnt remains 3.
- NoSlvPorts=3: R beat with sel=3 -> mst_r_ready_o=1, no slv_r_valid_o raised, err_o pulses once.
  - R-last for a port with cnt=0 -> forwarded, err_o pulses, cnt stays 0.
